// File: rtl/prbs_pkg.sv
// Shared constants for the 16-bit XNOR PRBS generator and checker.
package prbs_pkg;

   // Register width shared by the generator and checker LFSRs.
   localparam int PRBS_W = 16;

   // Feedback taps {15,14,12,3}.
   localparam logic [PRBS_W-1:0] PRBS_TAPS = 16'hD008;

   // All-ones is the XNOR lockup state and never appears in a good stream.
   localparam logic [PRBS_W-1:0] PRBS_LOCKUP = 16'hFFFF;

   // Checker FSM encoding, also the value driven on the state output.
   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/prbs16_predict.sv
// XNOR feedback of the 16-bit LFSR. The generator uses this as its next
// output bit, and the checker uses it as the predicted next received bit.
module prbs16_predict
   import prbs_pkg::*;
(
   input  logic [PRBS_W-1:0] sr_i,
   output logic              pred_o
);

   assign pred_o = ~(^(sr_i & PRBS_TAPS));

endmodule

// File: rtl/prbs16_checker.sv
// Self-synchronising receive checker for the 16-bit XNOR PRBS stream.
// Received bits are always shifted into the local register, so once 16 clean
// bits have arrived the register matches the generator state. A bit error
// therefore also corrupts the predictions of later bits while it sits on a tap.
module prbs16_checker
   import prbs_pkg::*;
#(
   parameter int CONFIRM_BITS = 32,
   parameter int WINDOW_BITS  = 64,
   parameter int LOSS_THRESH  = 8
)
(
   input  logic        CLK,
   input  logic        rst,
   input  logic        clr,
   input  logic        din_valid,
   input  logic        din,
   output logic        locked,
   output logic [1:0]  state,
   output logic        err_pulse,
   output logic [15:0] err_count,
   output logic [31:0] bit_count
);

   localparam logic [7:0]  CONF_LAST = 8'(CONFIRM_BITS - 1);
   localparam logic [15:0] WIN_LAST  = 16'(WINDOW_BITS - 1);
   localparam logic [15:0] LOSS_LAST = 16'(LOSS_THRESH - 1);

   logic [PRBS_W-1:0] sr_q, sr_d, sr_next;
   logic [1:0]        state_q, state_d;
   logic [4:0]        fill_q, fill_d;
   logic [7:0]        conf_q, conf_d;
   logic [15:0]       win_q, win_d;
   logic [15:0]       werr_q, werr_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic [31:0]       bit_cnt_q, bit_cnt_d;
   logic              locked_q, locked_d;
   logic              err_pulse_q, err_pulse_d;
   logic              pred;
   logic              mismatch;

   prbs16_predict u_predict (
      .sr_i   (sr_q),
      .pred_o (pred)
   );

   assign mismatch = din ^ pred;
   assign sr_next  = {sr_q[PRBS_W-2:0], din};

   // Next-state logic: shift, sync FSM, window monitor and status counters.
   always_comb begin
      sr_d        = sr_q;
      state_d     = state_q;
      fill_d      = fill_q;
      conf_d      = conf_q;
      win_d       = win_q;
      werr_d      = werr_q;
      err_cnt_d   = err_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      err_pulse_d = 1'b0;

      if (din_valid) begin
         sr_d = sr_next;
         case (state_q)
            ST_SEARCH: begin
               if (fill_q == 5'd15) begin
                  // A full register that is the lockup value cannot be a
                  // generator state, so keep filling.
                  fill_d = 5'd0;
                  if (sr_next != PRBS_LOCKUP) begin
                     state_d = ST_VERIFY;
                     conf_d  = 8'd0;
                  end
               end else begin
                  fill_d = fill_q + 5'd1;
               end
            end
            ST_VERIFY: begin
               if (mismatch) begin
                  state_d = ST_SEARCH;
                  fill_d  = 5'd0;
               end else if (conf_q == CONF_LAST) begin
                  state_d = ST_LOCKED;
                  win_d   = 16'd0;
                  werr_d  = 16'd0;
               end else begin
                  conf_d = conf_q + 8'd1;
               end
            end
            ST_LOCKED: begin
               if (bit_cnt_q != 32'hFFFF_FFFF) bit_cnt_d = bit_cnt_q + 32'd1;
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
               end
               // Threshold test includes the current bit, even on the wrap bit.
               if (mismatch && (werr_q >= LOSS_LAST)) begin
                  state_d = ST_SEARCH;
                  fill_d  = 5'd0;
               end else if (win_q == WIN_LAST) begin
                  win_d  = 16'd0;
                  werr_d = 16'd0;
               end else begin
                  win_d  = win_q + 16'd1;
                  werr_d = werr_q + {15'd0, mismatch};
               end
            end
            default: begin
               state_d = ST_SEARCH;
               fill_d  = 5'd0;
            end
         endcase
      end

      if (clr) begin
         err_cnt_d = 16'd0;
         bit_cnt_d = 32'd0;
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         sr_q        <= '0;
         state_q     <= ST_SEARCH;
         fill_q      <= '0;
         conf_q      <= '0;
         win_q       <= '0;
         werr_q      <= '0;
         err_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         sr_q        <= sr_d;
         state_q     <= state_d;
         fill_q      <= fill_d;
         conf_q      <= conf_d;
         win_q       <= win_d;
         werr_q      <= werr_d;
         err_cnt_q   <= err_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign locked    = locked_q;
   assign state     = state_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_cnt_q;
   assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker with default parameters
// (CONFIRM_BITS 32, WINDOW_BITS 64, LOSS_THRESH 8).
// With the received stream r = g ^ e fed back into the prediction register,
// the mismatch at bit n is e[n]^e[n-4]^e[n-13]^e[n-15]^e[n-16]. The expected
// counts below are worked out by hand from that relation.
module tb_prbs16_checker;

   logic        CLK = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        din_valid = 1'b0;
   logic        din = 1'b0;
   logic        locked;
   logic [1:0]  state;
   logic        err_pulse;
   logic [15:0] err_count;
   logic [31:0] bit_count;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] g;

   always #5 CLK = ~CLK;

   prbs16_checker dut (
      .CLK       (CLK),
      .rst       (rst),
      .clr       (clr),
      .din_valid (din_valid),
      .din       (din),
      .locked    (locked),
      .state     (state),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .bit_count (bit_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // One valid bit per call; sampling happens 1 time unit after the edge.
   task automatic send(input logic b);
      din       = b;
      din_valid = 1'b1;
      @(posedge CLK);
      #1;
      din_valid = 1'b0;
   endtask

   // Reference generator: XNOR LFSR, taps {15,14,12,3}, output = feedback.
   task automatic gen_bit(input logic inv);
      logic fb;
      fb = ~(g[15] ^ g[14] ^ g[12] ^ g[3]);
      g  = {g[14:0], fb};
      send(fb ^ inv);
   endtask

   task automatic gen_n(input int n);
      for (int i = 0; i < n; i++) gen_bit(1'b0);
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #10 rst = 1'b1;
      idle(2);
      g = 16'h0000;
   endtask

   task automatic lock_up(input string tag);
      do_reset();
      gen_n(48);
      check(tag, 32'(locked), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset values
      #12;
      check("rst_state", 32'(state), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_pulse", 32'(err_pulse), 32'd0);
      check("rst_errcnt", 32'(err_count), 32'd0);
      check("rst_bitcnt", bit_count, 32'd0);
      rst = 1'b1;
      idle(2);
      g = 16'h0000;

      // Clean generator stream: VERIFY after 16 bits, LOCKED after 48
      gen_n(15);
      check("fill15_state", 32'(state), 32'd0);
      gen_bit(1'b0);
      check("fill16_state", 32'(state), 32'd1);
      gen_n(31);
      check("bit47_locked", 32'(locked), 32'd0);
      check("bit47_state", 32'(state), 32'd1);
      gen_bit(1'b0);
      check("bit48_locked", 32'(locked), 32'd1);
      check("bit48_state", 32'(state), 32'd2);
      gen_n(1000);
      check("bit1048_bitcnt", bit_count, 32'd1000);
      check("bit1048_errcnt", 32'(err_count), 32'd0);

      // No valid strobe: nothing moves
      idle(3);
      check("idle_bitcnt", bit_count, 32'd1000);
      check("idle_locked", 32'(locked), 32'd1);

      // clr alone, then clr together with a valid locked bit
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
      check("clr_bitcnt", bit_count, 32'd0);
      check("clr_errcnt", 32'(err_count), 32'd0);
      check("clr_locked", 32'(locked), 32'd1);
      clr = 1'b1;
      gen_bit(1'b0);
      clr = 1'b0;
      check("clr_valid_bitcnt", bit_count, 32'd0);
      gen_n(5);
      check("post_clr_bitcnt", bit_count, 32'd5);

      // Single inversion: immediate error plus echoes at +4,+13,+15,+16
      gen_bit(1'b1);
      check("single_pulse", 32'(err_pulse), 32'd1);
      check("single_errcnt", 32'(err_count), 32'd1);
      check("single_locked", 32'(locked), 32'd1);
      idle(1);
      check("pulse_drop_idle", 32'(err_pulse), 32'd0);
      gen_n(3);
      check("single_p3_errcnt", 32'(err_count), 32'd1);
      check("single_p3_pulse", 32'(err_pulse), 32'd0);
      gen_bit(1'b0);
      check("single_p4_pulse", 32'(err_pulse), 32'd1);
      check("single_p4_errcnt", 32'(err_count), 32'd2);
      gen_n(12);
      check("single_p16_errcnt", 32'(err_count), 32'd5);
      check("single_p16_locked", 32'(locked), 32'd1);

      // Asynchronous reset while locked
      #2 rst = 1'b0;
      #1;
      check("async_rst_locked", 32'(locked), 32'd0);
      check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_errcnt", 32'(err_count), 32'd0);
      check("async_rst_bitcnt", bit_count, 32'd0);
      #5 rst = 1'b1;
      idle(1);

      // Loss of lock: inversions at window index 10,11 give errors at
      // 10,11,14,15,23,24,25,27; the 8th (index 27) drops lock
      lock_up("lossA_lock");
      gen_n(10);
      gen_bit(1'b1);
      gen_bit(1'b1);
      gen_n(14);
      check("lossA_7err_cnt", 32'(err_count), 32'd7);
      check("lossA_7err_locked", 32'(locked), 32'd1);
      gen_bit(1'b0);
      check("lossA_clean_locked", 32'(locked), 32'd1);
      gen_bit(1'b0);
      check("lossA_8err_locked", 32'(locked), 32'd0);
      check("lossA_8err_state", 32'(state), 32'd0);
      check("lossA_8err_pulse", 32'(err_pulse), 32'd1);
      check("lossA_8err_cnt", 32'(err_count), 32'd8);
      gen_n(16);
      check("relock16_state", 32'(state), 32'd1);
      gen_n(31);
      check("relock47_locked", 32'(locked), 32'd0);
      gen_bit(1'b0);
      check("relock48_locked", 32'(locked), 32'd1);
      check("relock48_errcnt", 32'(err_count), 32'd8);

      // Window wrap: errors at 47,48,51,52,60,61,62 then 64 (next window)
      lock_up("wrapB_lock");
      gen_n(47);
      gen_bit(1'b1);
      gen_bit(1'b1);
      gen_n(14);
      check("wrapB_7err_cnt", 32'(err_count), 32'd7);
      gen_bit(1'b0);
      check("wrapB_wrap_locked", 32'(locked), 32'd1);
      gen_bit(1'b0);
      check("wrapB_next_pulse", 32'(err_pulse), 32'd1);
      check("wrapB_next_errcnt", 32'(err_count), 32'd8);
      check("wrapB_next_locked", 32'(locked), 32'd1);
      check("wrapB_next_state", 32'(state), 32'd2);

      // Wrap bit is the 8th error of its window: errors 46,47,50,51,59,60,61,63
      lock_up("wrapC_lock");
      gen_n(46);
      gen_bit(1'b1);
      gen_bit(1'b1);
      gen_n(14);
      check("wrapC_7err_locked", 32'(locked), 32'd1);
      gen_bit(1'b0);
      check("wrapC_idx62_locked", 32'(locked), 32'd1);
      gen_bit(1'b0);
      check("wrapC_wrap_locked", 32'(locked), 32'd0);
      check("wrapC_wrap_state", 32'(state), 32'd0);

      // All-ones input never leaves SEARCH
      do_reset();
      for (int i = 0; i < 16; i++) send(1'b1);
      check("ones16_state", 32'(state), 32'd0);
      for (int i = 0; i < 40; i++) send(1'b1);
      check("ones56_state", 32'(state), 32'd0);
      check("ones56_locked", 32'(locked), 32'd0);

      // Mismatch at the 20th confirm bit returns to SEARCH
      do_reset();
      gen_n(16);
      check("verify_entry_state", 32'(state), 32'd1);
      gen_n(19);
      check("verify19_state", 32'(state), 32'd1);
      gen_bit(1'b1);
      check("verify20_state", 32'(state), 32'd0);
      check("verify20_pulse", 32'(err_pulse), 32'd0);
      check("verify20_errcnt", 32'(err_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
